// File: rtl/fp_round_pack_pkg.sv
// ----------------------------------------------------------------------------
// fp_round_pack_pkg
// Shared constants and types for the rounding/packing stage of the
// two's-complement to 9-bit float converter. The float format is
// {S, E[2:0], F[4:0]}, where F carries its leading one explicitly.
// ----------------------------------------------------------------------------
package fp_round_pack_pkg;

    localparam int EXP_W  = 3;
    localparam int FRAC_W = 5;
    localparam int FP_W   = 1 + EXP_W + FRAC_W;
    // Significand plus one carry bit, produced by adding the round bit
    localparam int SUM_W  = FRAC_W + 1;

    localparam logic [EXP_W-1:0]  EXP_MAX   = 3'd7;
    localparam logic [FRAC_W-1:0] FRAC_MAX  = 5'b11111;
    localparam logic [FRAC_W-1:0] FRAC_NORM = 5'b10000;

    // Stage-1 payload: sign, exponent and the rounded significand with carry
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [SUM_W-1:0]  sum6;
    } s1_t;

    // Round half up: the sixth bit simply adds into the significand LSB.
    function automatic logic [SUM_W-1:0] round_sum(input logic [FRAC_W-1:0] f,
                                                   input logic              rb);
        return {1'b0, f} + {{FRAC_W{1'b0}}, rb};
    endfunction

endpackage

// File: rtl/fp_round_pack_if.sv
// ----------------------------------------------------------------------------
// fp_round_pack_if
// Upstream and downstream streams of the rounding/packing stage.
//   Upstream   : in_valid, in_ready, Sign, E, F, SixthBit
//   Downstream : out_valid, out_ready, FP, Saturated
// Handshake: a beat transfers on a rising clock edge where valid and ready
// are both 1. While valid=1 and ready=0 the sender holds valid and data
// unchanged. Ready may depend combinationally on the far side's ready.
// Modports: slave  = the rounding stage itself
//           master = the agent feeding inputs and consuming outputs
// ----------------------------------------------------------------------------
interface fp_round_pack_if;
    import fp_round_pack_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              Sign;
    logic [EXP_W-1:0]  E;
    logic [FRAC_W-1:0] F;
    logic              SixthBit;

    logic              out_valid;
    logic              out_ready;
    logic [FP_W-1:0]   FP;
    logic              Saturated;

    modport slave (
        input  in_valid, Sign, E, F, SixthBit, out_ready,
        output in_ready, out_valid, FP, Saturated
    );

    modport master (
        output in_valid, Sign, E, F, SixthBit, out_ready,
        input  in_ready, out_valid, FP, Saturated
    );

endinterface

// File: rtl/fp_round_pack_round_norm.sv
// ----------------------------------------------------------------------------
// fp_round_norm
// Combinational carry / renormalise / saturate of a rounded significand.
//   i_e    : exponent from the split stage
//   i_sum6 : {carry, significand} after adding the round bit
//   o_e    : resulting exponent
//   o_f    : resulting 5-bit significand
//   o_sat  : result clamped to the largest representable magnitude
// ----------------------------------------------------------------------------
module fp_round_norm
    import fp_round_pack_pkg::*;
(
    input  logic [EXP_W-1:0]  i_e,
    input  logic [SUM_W-1:0]  i_sum6,
    output logic [EXP_W-1:0]  o_e,
    output logic [FRAC_W-1:0] o_f,
    output logic              o_sat
);

    always_comb begin
        o_e   = i_e;
        o_f   = i_sum6[FRAC_W-1:0];
        o_sat = 1'b0;
        // A carry out of the significand means it rounded up to exactly 2.0;
        // shift right by bumping the exponent, unless it is already at max.
        if (i_sum6[FRAC_W]) begin
            if (i_e == EXP_MAX) begin
                o_e   = EXP_MAX;
                o_f   = FRAC_MAX;
                o_sat = 1'b1;
            end else begin
                o_e   = i_e + EXP_W'(1);
                o_f   = FRAC_NORM;
            end
        end
    end

endmodule

// File: rtl/fp_round_pack.sv
// ----------------------------------------------------------------------------
// fp_round_pack
// Two-stage pipeline that rounds (half up), renormalises, saturates and packs
// the split-stage output into a 9-bit float, with a saturation event counter.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : slave side of fp_round_pack_if (input and output streams)
//   SatCount : saturated results delivered downstream; sticks at all-ones
// Parameters:
//   CNT_W    : width of SatCount
// ----------------------------------------------------------------------------
module fp_round_pack
    import fp_round_pack_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    fp_round_pack_if.slave    bus,
    output logic [CNT_W-1:0]  SatCount
);

    logic              r_s1_valid;
    s1_t               r_s1;
    logic              r_s2_valid;
    logic [FP_W-1:0]   r_fp;
    logic              r_sat;
    logic [CNT_W-1:0]  r_sat_cnt;

    logic              w_adv1;
    logic              w_adv2;
    logic [EXP_W-1:0]  w_e;
    logic [FRAC_W-1:0] w_f;
    logic              w_sat;

    // A stage may advance when it is empty or its successor advances. With no
    // skid buffer, in_ready follows out_ready combinationally when full.
    assign w_adv2       = !r_s2_valid || bus.out_ready;
    assign w_adv1       = !r_s1_valid || w_adv2;
    assign bus.in_ready = w_adv1;

    // Stage 1: capture sign/exponent and add the round bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1.sign <= bus.Sign;
                r_s1.exp  <= bus.E;
                r_s1.sum6 <= round_sum(bus.F, bus.SixthBit);
            end
        end
    end

    fp_round_norm u_norm (
        .i_e    (r_s1.exp),
        .i_sum6 (r_s1.sum6),
        .o_e    (w_e),
        .o_f    (w_f),
        .o_sat  (w_sat)
    );

    // Stage 2: normalised, packed result; held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_fp       <= '0;
            r_sat      <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_fp  <= {r_s1.sign, w_e, w_f};
                r_sat <= w_sat;
            end
        end
    end

    // Count saturated beats as they are delivered; stop at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_cnt <= '0;
        end else if (r_s2_valid && bus.out_ready && r_sat && (r_sat_cnt != '1)) begin
            r_sat_cnt <= r_sat_cnt + CNT_W'(1);
        end
    end

    assign bus.out_valid = r_s2_valid;
    assign bus.FP        = r_fp;
    assign bus.Saturated = r_sat;
    assign SatCount      = r_sat_cnt;

endmodule
